// File: rtl/bythoven_pkg.sv
// Shared definitions for the score sequencer: opcodes, word field positions,
// FSM states and tempo/duration arithmetic helpers.
package bythoven_pkg;

  typedef enum logic [1:0] {
    OP_NOTE  = 2'b00,
    OP_REST  = 2'b01,
    OP_TEMPO = 2'b10,
    OP_HALT  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INS,
    S_DIV,
    S_PLAY,
    S_HALTED
  } state_e;

  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 14;
  localparam int unsigned VOL_MSB  = 13;
  localparam int unsigned VOL_LSB  = 12;
  localparam int unsigned DUR_MSB  = 11;
  localparam int unsigned DUR_LSB  = 8;
  localparam int unsigned OCT_MSB  = 7;
  localparam int unsigned OCT_LSB  = 4;
  localparam int unsigned NOTE_MSB = 3;
  localparam int unsigned NOTE_LSB = 0;
  localparam int unsigned BPM_MSB  = 7;
  localparam int unsigned BPM_LSB  = 0;

  function automatic logic [31:0] ticks_per_min_f(input longint unsigned clk_hz);
    longint unsigned t;
    t = clk_hz * 64'd60;
    return t[31:0];
  endfunction

  function automatic logic [31:0] eighth_cycles_f(input longint unsigned clk_hz,
                                                  input longint unsigned bpm);
    longint unsigned q;
    q = (clk_hz * 64'd60) / (bpm * 64'd8);
    return q[31:0];
  endfunction

  // dur 0 means 16 eighths; product saturates, and never returns 0 so PLAY always ends
  function automatic logic [31:0] dur_cycles_f(input logic [3:0] dur, input logic [31:0] eighth);
    logic [4:0]  beats;
    logic [36:0] prod;
    beats = (dur == 4'd0) ? 5'd16 : {1'b0, dur};
    prod  = {32'd0, beats} * {5'd0, eighth};
    if (prod[36:32] != 5'd0) return '1;
    if (prod == 37'd0) return 32'd1;
    return prod[31:0];
  endfunction

endpackage

// File: rtl/seq_divider.sv
// 32/32 unsigned restoring divider, one quotient bit per cycle; done pulses
// for one cycle when the quotient is ready. A new start aborts any divide.
module seq_divider (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient
);

  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        run_q, run_d, done_q, done_d;
  logic [32:0] shifted, diff;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (!diff[32]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = shifted[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/note_sequencer.sv
// Score playback controller: SRAM fetch unit with one-word prefetch buffer,
// instruction FSM, tempo divider and eighth-beat duration counter.
module note_sequencer
  import bythoven_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned DEFAULT_BPM = 96,
  parameter int unsigned SRAM_WAIT   = 3,
  parameter logic [17:0] START_ADDR  = 18'd0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        stop,
  output logic [17:0] SRAM_A,
  input  logic [15:0] SRAM_D,
  output logic        tone_en,
  output logic [3:0]  tone_note,
  output logic [3:0]  tone_octave,
  output logic [1:0]  tone_volume,
  output logic        busy,
  output logic        halted
);

  localparam logic [31:0]  EIGHTH_DEFAULT = eighth_cycles_f(CLK_HZ, DEFAULT_BPM);
  localparam logic [31:0]  TICKS_PER_MIN  = ticks_per_min_f(CLK_HZ);
  localparam int unsigned  FW             = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
  localparam logic [FW-1:0] FETCH_LAST    = FW'(SRAM_WAIT - 1);

  state_e      state_q, state_d;
  logic [17:0] pc_q, pc_d;
  logic [15:0] pbuf_q, pbuf_d;
  logic        pbuf_valid_q, pbuf_valid_d;
  logic        fetch_act_q, fetch_act_d;
  logic [FW-1:0] fetch_cnt_q, fetch_cnt_d;
  logic        fetch_halt_q, fetch_halt_d;
  logic [31:0] eighth_q, eighth_d;
  logic [31:0] dur_cnt_q, dur_cnt_d;
  logic        tempo_zero_q, tempo_zero_d;
  logic        tone_en_q, tone_en_d;
  logic [3:0]  tone_note_q, tone_note_d, tone_oct_q, tone_oct_d;
  logic [1:0]  tone_vol_q, tone_vol_d;

  op_e         pbuf_op;
  logic        run_w, load_play, begin_run, note_ok;
  logic        div_start, div_done;
  logic [31:0] div_quo, div_divisor;

  assign pbuf_op     = op_e'(pbuf_q[OP_MSB:OP_LSB]);
  assign run_w       = (state_q == S_WAIT_INS) || (state_q == S_DIV) || (state_q == S_PLAY);
  assign div_divisor = {21'd0, pbuf_q[BPM_MSB:BPM_LSB], 3'd0};

  seq_divider u_div (
    .CLK      (CLK),
    .RST      (RST),
    .start    (div_start),
    .dividend (TICKS_PER_MIN),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pbuf_d       = pbuf_q;
    pbuf_valid_d = pbuf_valid_q;
    fetch_act_d  = fetch_act_q;
    fetch_cnt_d  = fetch_cnt_q;
    fetch_halt_d = fetch_halt_q;
    eighth_d     = eighth_q;
    dur_cnt_d    = dur_cnt_q;
    tempo_zero_d = tempo_zero_q;
    tone_en_d    = tone_en_q;
    tone_note_d  = tone_note_q;
    tone_oct_d   = tone_oct_q;
    tone_vol_d   = tone_vol_q;
    load_play    = 1'b0;
    begin_run    = 1'b0;
    note_ok      = 1'b0;
    div_start    = 1'b0;

    // Fetch runs beside the FSM; the issue cycle is registered, then SRAM_A is held SRAM_WAIT cycles.
    if (fetch_act_q) begin
      if (fetch_cnt_q == FETCH_LAST) begin
        pbuf_d       = SRAM_D;
        pbuf_valid_d = 1'b1;
        fetch_act_d  = 1'b0;
        fetch_cnt_d  = '0;
        pc_d         = pc_q + 18'd1;
        if (SRAM_D[OP_MSB:OP_LSB] == OP_HALT) fetch_halt_d = 1'b1;
      end else begin
        fetch_cnt_d = fetch_cnt_q + FW'(1);
      end
    end else if (run_w && !pbuf_valid_q && !fetch_halt_q) begin
      fetch_act_d = 1'b1;
      fetch_cnt_d = '0;
    end

    case (state_q)
      S_IDLE, S_HALTED: if (start) begin_run = 1'b1;
      S_WAIT_INS: begin
        if (pbuf_valid_q) begin
          pbuf_valid_d = 1'b0;
          case (pbuf_op)
            OP_NOTE, OP_REST: load_play = 1'b1;
            OP_TEMPO: begin
              tempo_zero_d = (pbuf_q[BPM_MSB:BPM_LSB] == 8'd0);
              div_start    = (pbuf_q[BPM_MSB:BPM_LSB] != 8'd0);
              state_d      = S_DIV;
            end
            default: state_d = S_HALTED;
          endcase
        end
      end
      S_DIV: begin
        if (tempo_zero_q) begin
          state_d = S_WAIT_INS;
        end else if (div_done) begin
          eighth_d = div_quo;
          state_d  = S_WAIT_INS;
        end
      end
      S_PLAY: begin
        if (dur_cnt_q == 32'd1) begin
          if (pbuf_valid_q && !pbuf_q[OP_MSB]) begin
            load_play = 1'b1;
          end else begin
            state_d     = S_WAIT_INS;
            tone_en_d   = 1'b0;
            tone_note_d = '0;
            tone_oct_d  = '0;
            tone_vol_d  = '0;
          end
        end else begin
          dur_cnt_d = dur_cnt_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (begin_run) begin
      state_d      = S_WAIT_INS;
      pc_d         = START_ADDR;
      pbuf_valid_d = 1'b0;
      fetch_act_d  = 1'b0;
      fetch_cnt_d  = '0;
      fetch_halt_d = 1'b0;
      eighth_d     = EIGHTH_DEFAULT;
    end

    if (load_play) begin
      note_ok      = (pbuf_op == OP_NOTE) && (pbuf_q[NOTE_MSB:NOTE_LSB] < 4'd12);
      pbuf_valid_d = 1'b0;
      state_d      = S_PLAY;
      dur_cnt_d    = dur_cycles_f(pbuf_q[DUR_MSB:DUR_LSB], eighth_q);
      tone_en_d    = note_ok;
      tone_note_d  = note_ok ? pbuf_q[NOTE_MSB:NOTE_LSB] : 4'd0;
      tone_oct_d   = note_ok ? pbuf_q[OCT_MSB:OCT_LSB] : 4'd0;
      tone_vol_d   = note_ok ? pbuf_q[VOL_MSB:VOL_LSB] : 2'd0;
    end

    // stop overrides everything, including a start or a fetch completing this cycle
    if (stop) begin
      state_d      = S_IDLE;
      pc_d         = START_ADDR;
      pbuf_valid_d = 1'b0;
      fetch_act_d  = 1'b0;
      fetch_cnt_d  = '0;
      fetch_halt_d = 1'b0;
      dur_cnt_d    = '0;
      tone_en_d    = 1'b0;
      tone_note_d  = '0;
      tone_oct_d   = '0;
      tone_vol_d   = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      pc_q         <= START_ADDR;
      pbuf_q       <= '0;
      pbuf_valid_q <= 1'b0;
      fetch_act_q  <= 1'b0;
      fetch_cnt_q  <= '0;
      fetch_halt_q <= 1'b0;
      eighth_q     <= EIGHTH_DEFAULT;
      dur_cnt_q    <= '0;
      tempo_zero_q <= 1'b0;
      tone_en_q    <= 1'b0;
      tone_note_q  <= '0;
      tone_oct_q   <= '0;
      tone_vol_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pbuf_q       <= pbuf_d;
      pbuf_valid_q <= pbuf_valid_d;
      fetch_act_q  <= fetch_act_d;
      fetch_cnt_q  <= fetch_cnt_d;
      fetch_halt_q <= fetch_halt_d;
      eighth_q     <= eighth_d;
      dur_cnt_q    <= dur_cnt_d;
      tempo_zero_q <= tempo_zero_d;
      tone_en_q    <= tone_en_d;
      tone_note_q  <= tone_note_d;
      tone_oct_q   <= tone_oct_d;
      tone_vol_q   <= tone_vol_d;
    end
  end

  assign SRAM_A      = pc_q;
  assign tone_en     = tone_en_q;
  assign tone_note   = tone_note_q;
  assign tone_octave = tone_oct_q;
  assign tone_volume = tone_vol_q;
  assign busy        = run_w;
  assign halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer at CLK_HZ=800, DEFAULT_BPM=60 (100 cycles per eighth),
// SRAM_WAIT=3; a second instance starts at the top of the address space.
module tb_note_sequencer;

  localparam logic [15:0] HALT_W = 16'hC000;

  typedef struct packed {
    logic [3:0]  note;
    logic [3:0]  oct;
    logic [1:0]  vol;
    logic [15:0] at;
    logic [15:0] len;
  } ev_t;

  typedef struct packed {
    logic [2:0][15:0] w;
    logic [1:0]       nev;
    ev_t [1:0]        ev;
    logic [15:0]      halt_at;
  } vec_t;

  typedef struct packed {
    logic [3:0]  note;
    logic [3:0]  oct;
    logic [1:0]  vol;
    logic [31:0] at;
    logic [31:0] len;
  } sb_t;

  logic        CLK = 1'b0;
  logic        RST, start, start_w, stop;
  logic [17:0] sram_a, sram_a_w;
  logic [15:0] sram_d, sram_d_w;
  logic        tone_en, busy, halted, tone_en_w, busy_w, halted_w;
  logic [3:0]  tone_note, tone_octave, tone_note_w, tone_octave_w;
  logic [1:0]  tone_volume, tone_volume_w;

  logic [15:0] mem [16];
  logic [15:0] mem_top;
  logic [31:0] cyc = '0;
  int          total = 0;
  int          bad = 0;
  sb_t         sb_q [$];
  vec_t        vecs [5];

  logic        seg_on = 1'b0;
  logic [9:0]  seg_b;
  logic [31:0] seg_t;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 32'd1;

  assign sram_d   = (sram_a == 18'h3FFFF) ? mem_top :
                    (sram_a[17:4] == 14'd0) ? mem[sram_a[3:0]] : HALT_W;
  assign sram_d_w = (sram_a_w == 18'h3FFFF) ? mem_top :
                    (sram_a_w[17:4] == 14'd0) ? mem[sram_a_w[3:0]] : HALT_W;

  note_sequencer #(.CLK_HZ(800), .DEFAULT_BPM(60), .SRAM_WAIT(3), .START_ADDR(18'd0)) dut (
    .CLK(CLK), .RST(RST), .start(start), .stop(stop), .SRAM_A(sram_a), .SRAM_D(sram_d),
    .tone_en(tone_en), .tone_note(tone_note), .tone_octave(tone_octave),
    .tone_volume(tone_volume), .busy(busy), .halted(halted)
  );

  note_sequencer #(.CLK_HZ(800), .DEFAULT_BPM(60), .SRAM_WAIT(3), .START_ADDR(18'h3FFFF)) dut_w (
    .CLK(CLK), .RST(RST), .start(start_w), .stop(stop), .SRAM_A(sram_a_w), .SRAM_D(sram_d_w),
    .tone_en(tone_en_w), .tone_note(tone_note_w), .tone_octave(tone_octave_w),
    .tone_volume(tone_volume_w), .busy(busy_w), .halted(halted_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic ev_t mkev(input int unsigned n, o, v, at, len);
    ev_t e;
    e.note = 4'(n); e.oct = 4'(o); e.vol = 2'(v); e.at = 16'(at); e.len = 16'(len);
    return e;
  endfunction

  function automatic vec_t mk(input logic [15:0] w0, w1, w2, input int unsigned nev,
                              input ev_t e0, e1, input int unsigned halt_at);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
    v.nev = 2'(nev); v.ev[0] = e0; v.ev[1] = e1; v.halt_at = 16'(halt_at);
    return v;
  endfunction

  task automatic close_seg(input logic [31:0] endc);
    sb_t e;
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_note: got note=%0d starting cycle %0d expected none", seg_b[9:6], seg_t);
    end else begin
      e = sb_q.pop_front();
      check("note", 32'(seg_b[9:6]), 32'(e.note));
      check("octave", 32'(seg_b[5:2]), 32'(e.oct));
      check("volume", 32'(seg_b[1:0]), 32'(e.vol));
      check("note_start", seg_t, e.at);
      check("note_len", endc - seg_t, e.len);
    end
  endtask

  // Scoreboard consumer: each constant stretch of tone_en=1 is one note event
  always @(negedge CLK) begin
    if (seg_on && (!tone_en || {tone_note, tone_octave, tone_volume} != seg_b)) begin
      close_seg(cyc);
      seg_on = 1'b0;
    end
    if (tone_en && !seg_on) begin
      seg_on = 1'b1;
      seg_b  = {tone_note, tone_octave, tone_volume};
      seg_t  = cyc;
    end
  end

  task automatic load_score(input vec_t v);
    for (int i = 0; i < 16; i++) mem[i] = HALT_W;
    for (int i = 0; i < 3; i++) mem[i] = v.w[i];
  endtask

  task automatic push_events(input vec_t v, input logic [31:0] t0);
    sb_t e;
    for (int i = 0; i < int'(v.nev); i++) begin
      e.note = v.ev[i].note; e.oct = v.ev[i].oct; e.vol = v.ev[i].vol;
      e.at = t0 + 32'(v.ev[i].at); e.len = 32'(v.ev[i].len);
      sb_q.push_back(e);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] t0, rel, hat;
    load_score(v);
    hat = 32'(v.halt_at);
    @(negedge CLK);
    start = 1'b1;
    t0 = cyc + 32'd1;
    push_events(v, t0);
    @(negedge CLK);
    start = 1'b0;
    rel = cyc - t0;
    while (!halted && rel < hat + 32'd30) begin
      @(negedge CLK);
      rel = cyc - t0;
      if (rel == hat - 32'd1) begin
        check("busy_before_halt", 32'(busy), 32'd1);
        check("halted_early", 32'(halted), 32'd0);
      end
    end
    check("halt_cycle", rel, hat);
    check("busy_after_halt", 32'(busy), 32'd0);
    repeat (2) @(negedge CLK);
    check("events_left", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] t0, rel, hi;
    sb_t e;
    RST = 1'b1; start = 1'b0; start_w = 1'b0; stop = 1'b0;
    mem_top = HALT_W;
    for (int i = 0; i < 16; i++) mem[i] = HALT_W;

    vecs[0] = mk(16'h2249, HALT_W, HALT_W, 1, mkev(9, 4, 2, 5, 200), '0, 206);
    vecs[1] = mk(16'h1130, 16'h1134, HALT_W, 2, mkev(0, 3, 1, 5, 100), mkev(4, 3, 1, 105, 100), 206);
    vecs[2] = mk(16'h8078, 16'h1130, HALT_W, 1, mkev(0, 3, 1, 39, 50), '0, 90);
    vecs[3] = mk(16'h8000, 16'h1130, HALT_W, 1, mkev(0, 3, 1, 10, 100), '0, 111);
    vecs[4] = mk(16'h4000, 16'h113D, HALT_W, 0, '0, '0, 1706);

    repeat (3) @(negedge CLK);
    check("rst_tone_en", 32'(tone_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_sram_a", 32'(sram_a), 32'd0);
    check("rst_sram_a_wrap", 32'(sram_a_w), 32'h3FFFF);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // stop and start in the same cycle, mid-note
    load_score(vecs[0]);
    @(negedge CLK);
    start = 1'b1;
    t0 = cyc + 32'd1;
    e.note = 4'd9; e.oct = 4'd4; e.vol = 2'd2; e.at = t0 + 32'd5; e.len = 32'd46;
    sb_q.push_back(e);
    @(negedge CLK);
    start = 1'b0;
    repeat (50) @(negedge CLK);
    check("tone_mid_note", 32'(tone_en), 32'd1);
    stop = 1'b1; start = 1'b1;
    @(negedge CLK);
    stop = 1'b0; start = 1'b0;
    check("stop_tone_en", 32'(tone_en), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_sram_a", 32'(sram_a), 32'd0);
    repeat (10) @(negedge CLK);
    check("stop_stays_idle", 32'(busy), 32'd0);
    check("stop_events_left", 32'(sb_q.size()), 32'd0);
    run_vec(vecs[0]);

    // address wrap on the second instance
    mem_top = 16'h3157;
    for (int i = 0; i < 16; i++) mem[i] = HALT_W;
    @(negedge CLK);
    start_w = 1'b1;
    t0 = cyc + 32'd1;
    @(negedge CLK);
    start_w = 1'b0;
    rel = cyc - t0;
    while (!tone_en_w && rel < 32'd20) begin
      @(negedge CLK);
      rel = cyc - t0;
    end
    check("wrap_rise_cycle", rel, 32'd5);
    check("wrap_sram_a", 32'(sram_a_w), 32'd0);
    check("wrap_note", 32'(tone_note_w), 32'd7);
    check("wrap_octave", 32'(tone_octave_w), 32'd5);
    check("wrap_volume", 32'(tone_volume_w), 32'd3);
    hi = 32'd0;
    while (tone_en_w && hi < 32'd300) begin
      @(negedge CLK);
      hi++;
    end
    check("wrap_len", hi, 32'd100);
    rel = cyc - t0;
    while (!halted_w && rel < 32'd200) begin
      @(negedge CLK);
      rel = cyc - t0;
    end
    check("wrap_halt_cycle", rel, 32'd106);

    // asynchronous reset while a note plays and the next word is being fetched
    @(negedge CLK);
    start_w = 1'b1;
    @(negedge CLK);
    start_w = 1'b0;
    repeat (7) @(negedge CLK);
    check("pre_rst_tone", 32'(tone_en_w), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("async_rst_tone_en", 32'(tone_en_w), 32'd0);
    check("async_rst_note", 32'({tone_note_w, tone_octave_w, tone_volume_w}), 32'd0);
    check("async_rst_busy", 32'(busy_w), 32'd0);
    check("async_rst_halted", 32'(halted_w), 32'd0);
    check("async_rst_sram_a", 32'(sram_a_w), 32'h3FFFF);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("post_rst_idle", 32'(busy_w), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
